// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life pattern selector.
package gol_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int GOL_NUM_PAT = 8;
  localparam int GOL_PAT_W   = 2;

  localparam int GLIDER  = 0;
  localparam int BLINKER = 1;
  localparam int BEACON  = 2;
  localparam int ACORN   = 3;

endpackage

// File: rtl/pattern_sel_ctrl_if.sv
// Selector <-> algorithm/display bundle; auto_en only exists with PATTERN_SEL_AUTO_EN.
// Handshake: load_req stays high until load_ack is sampled high; the transfer ends when load_ack falls.
interface pattern_sel_ctrl_if
  import gol_pkg::*;
#(
    parameter int NUM_PAT = GOL_NUM_PAT,
    parameter int SEL_W   = $clog2(NUM_PAT),
    parameter int PAT_W   = GOL_PAT_W,
    parameter int STAT_W  = 4
);
    logic [SEL_W-1:0]         sel_sw;
    logic [NUM_PAT*PAT_W-1:0] pattern_bus;
    logic                     load_ack;
    logic [PAT_W-1:0]         out_pattern;
    logic [STAT_W-1:0]        Q;
    logic                     load_req;
    logic                     busy;
    logic                     sel_err;
    state_t                   dbg_state;
`ifdef PATTERN_SEL_AUTO_EN
    logic                     auto_en;

    modport master (
        input  sel_sw, pattern_bus, load_ack, auto_en,
        output out_pattern, Q, load_req, busy, sel_err, dbg_state
    );
    modport slave (
        output sel_sw, pattern_bus, load_ack, auto_en,
        input  out_pattern, Q, load_req, busy, sel_err, dbg_state
    );
`else
    modport master (
        input  sel_sw, pattern_bus, load_ack,
        output out_pattern, Q, load_req, busy, sel_err, dbg_state
    );
    modport slave (
        output sel_sw, pattern_bus, load_ack,
        input  out_pattern, Q, load_req, busy, sel_err, dbg_state
    );
`endif
endinterface

// File: rtl/sel_debounce.sv
// Two-flop synchroniser plus stability counter; commit pulses once per new stable value.
module sel_debounce #(
    parameter int W          = 3,
    parameter int DEB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         commit
);
    localparam int            CW     = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LP_MAX = CW'(DEB_CYCLES - 1);

    logic [W-1:0]  r_sync1, r_sync2, r_cand, r_committed;
    logic [CW-1:0] r_cnt;
    logic          r_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_cand      <= '0;
            r_committed <= '0;
            r_cnt       <= '0;
            r_commit    <= 1'b0;
        end else begin
            r_sync1  <= din;
            r_sync2  <= r_sync1;
            r_commit <= 1'b0;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else begin
                if (r_cnt != LP_MAX) r_cnt <= r_cnt + 1'b1;
                // Saturated counter plus a changed value is the only way to commit.
                if (r_cnt == LP_MAX && r_cand != r_committed) begin
                    r_committed <= r_cand;
                    r_commit    <= 1'b1;
                end
            end
        end
    end

    assign dout   = r_committed;
    assign commit = r_commit;
endmodule

// File: rtl/pattern_sel_ctrl.sv
// Debounced pattern selector with req/ack load handshake to the life algorithm.
// Optional timed auto-advance via PATTERN_SEL_AUTO_EN.
module pattern_sel_ctrl
  import gol_pkg::*;
#(
    parameter int NUM_PAT    = GOL_NUM_PAT,
    parameter int SEL_W      = $clog2(NUM_PAT),
    parameter int PAT_W      = GOL_PAT_W,
    parameter int DEB_CYCLES = 16,
    parameter int STAT_W     = 4
`ifdef PATTERN_SEL_AUTO_EN
    , parameter int AUTO_PERIOD = 50_000_000
`endif
) (
    input logic                clk,
    input logic                rst_n,
    pattern_sel_ctrl_if.master bus
);
    localparam logic [SEL_W:0] LP_NUM_PAT = (SEL_W + 1)'(NUM_PAT);

    logic [SEL_W-1:0] w_deb_val;
    logic             w_deb_commit;

    sel_debounce #(.W(SEL_W), .DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (bus.sel_sw),
        .dout   (w_deb_val),
        .commit (w_deb_commit)
    );

    state_t           r_state;
    logic [SEL_W-1:0] r_active_sel, r_pend_sel;
    logic             r_pending, r_load_req, r_busy, r_sel_err;
    logic [PAT_W-1:0] r_out_pattern;

    logic             w_in_range, w_valid_commit, w_next_pend;
    logic [SEL_W-1:0] w_next_sel;
    logic             w_auto_fire;
    logic [SEL_W-1:0] w_auto_sel;

    assign w_in_range     = {1'b0, w_deb_val} < LP_NUM_PAT;
    assign w_valid_commit = w_deb_commit & w_in_range;
    // On HOLD exit a same-cycle commit supersedes whatever is pending.
    assign w_next_pend    = r_pending | w_valid_commit;
    assign w_next_sel     = w_valid_commit ? w_deb_val : r_pend_sel;

`ifdef PATTERN_SEL_AUTO_EN
    localparam int APW = $clog2(AUTO_PERIOD + 1);
    logic [APW-1:0] r_auto_cnt;

    assign w_auto_fire = bus.auto_en && (r_state == IDLE) && (r_auto_cnt == APW'(AUTO_PERIOD - 1));
    assign w_auto_sel  = (r_active_sel == SEL_W'(NUM_PAT - 1)) ? '0 : r_active_sel + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_auto_cnt <= '0;
        else if (w_valid_commit || !bus.auto_en || w_auto_fire) r_auto_cnt <= '0;
        else if (r_state == IDLE) r_auto_cnt <= r_auto_cnt + 1'b1;
    end
`else
    assign w_auto_fire = 1'b0;
    assign w_auto_sel  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_active_sel <= '0;
            r_pend_sel   <= '0;
            r_pending    <= 1'b0;
            r_load_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_sel_err <= w_deb_commit & ~w_in_range;
            case (r_state)
                BOOT: begin
                    if (w_valid_commit) begin
                        r_pend_sel <= w_deb_val;
                        r_pending  <= 1'b1;
                    end
                    r_state <= REQ;
                    r_busy  <= 1'b1;
                end
                IDLE: begin
                    if (w_valid_commit) begin
                        r_active_sel <= w_deb_val;
                        r_state      <= REQ;
                        r_busy       <= 1'b1;
                    end else if (w_auto_fire) begin
                        r_active_sel <= w_auto_sel;
                        r_state      <= REQ;
                        r_busy       <= 1'b1;
                    end
                end
                REQ: begin
                    if (w_valid_commit) begin
                        r_pend_sel <= w_deb_val;
                        r_pending  <= 1'b1;
                    end
                    // First REQ cycle lets out_pattern settle before load_req rises.
                    if (!r_load_req) begin
                        r_load_req <= 1'b1;
                    end else if (bus.load_ack) begin
                        r_load_req <= 1'b0;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (!bus.load_ack) begin
                        r_pending <= 1'b0;
                        if (w_next_pend) begin
                            r_active_sel <= w_next_sel;
                            r_state      <= REQ;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_valid_commit) begin
                        r_pend_sel <= w_deb_val;
                        r_pending  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= BOOT;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_out_pattern <= '0;
        else        r_out_pattern <= bus.pattern_bus[int'(r_active_sel) * PAT_W +: PAT_W];
    end

    assign bus.out_pattern = r_out_pattern;
    assign bus.Q           = STAT_W'(r_active_sel);
    assign bus.load_req    = r_load_req;
    assign bus.busy        = r_busy;
    assign bus.sel_err     = r_sel_err;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_pattern_sel_ctrl.sv
// Scoreboard bench for pattern_sel_ctrl: an 8-pattern and a 6-pattern instance share clock and reset.
module tb_pattern_sel_ctrl;
  import gol_pkg::*;

  typedef struct packed {
    logic [3:0] q;
    logic [1:0] pat;
    logic [7:0] len;
  } exp_t;

  logic clk;
  logic rst_n;
  logic hold8;
  logic [2:0] dly8, dly6;
  int checks, errors;

  exp_t exp8_q[$];
  exp_t exp6_q[$];
  logic [3:0] err6_q[$];

  pattern_sel_ctrl_if #(.NUM_PAT(8), .PAT_W(2), .STAT_W(4)) if8 ();
  pattern_sel_ctrl_if #(.NUM_PAT(6), .PAT_W(2), .STAT_W(4)) if6 ();

  pattern_sel_ctrl #(.NUM_PAT(8), .PAT_W(2), .DEB_CYCLES(16), .STAT_W(4)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.master)
  );

  pattern_sel_ctrl #(.NUM_PAT(6), .PAT_W(2), .DEB_CYCLES(16), .STAT_W(4)) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if6.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // algorithm model: ack follows load_req three cycles later; hold8 forces it high
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly8 <= '0;
      dly6 <= '0;
    end else begin
      dly8 <= {dly8[1:0], if8.load_req};
      dly6 <= {dly6[1:0], if6.load_req};
    end
  end
  assign if8.load_ack = hold8 | dly8[2];
  assign if6.load_ack = dly6[2];

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // monitor: each load_req rising edge pops one expected load
  exp_t m8_cur, m6_cur;
  logic m8_prev, m6_prev, e6_prev;
  int   m8_len, m6_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      m8_prev = 1'b0;
      m8_len  = 0;
      m8_cur  = '0;
    end else begin
      if (if8.load_req && !m8_prev) begin
        m8_len = 1;
        if (exp8_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL load8_unexpected: got load with Q=%0d, required none", if8.Q);
          m8_cur = '0;
        end else begin
          m8_cur = exp8_q.pop_front();
          chk("load8_q", int'(if8.Q), int'(m8_cur.q));
          chk("load8_pat", int'(if8.out_pattern), int'(m8_cur.pat));
        end
      end else if (if8.load_req) begin
        m8_len++;
      end else if (m8_prev && m8_cur.len != 0) begin
        chk("load8_len", m8_len, int'(m8_cur.len));
        chk("load8_pat_stable", int'(if8.out_pattern), int'(m8_cur.pat));
      end
      m8_prev = if8.load_req;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m6_prev = 1'b0;
      m6_len  = 0;
      m6_cur  = '0;
      e6_prev = 1'b0;
    end else begin
      if (if6.load_req && !m6_prev) begin
        m6_len = 1;
        if (exp6_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL load6_unexpected: got load with Q=%0d, required none", if6.Q);
          m6_cur = '0;
        end else begin
          m6_cur = exp6_q.pop_front();
          chk("load6_q", int'(if6.Q), int'(m6_cur.q));
          chk("load6_pat", int'(if6.out_pattern), int'(m6_cur.pat));
        end
      end else if (if6.load_req) begin
        m6_len++;
      end else if (m6_prev && m6_cur.len != 0) begin
        chk("load6_len", m6_len, int'(m6_cur.len));
      end
      m6_prev = if6.load_req;

      if (e6_prev) begin
        chk("err6_one_cycle", int'(if6.sel_err), 0);
      end else if (if6.sel_err) begin
        if (err6_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL err6_unexpected: got sel_err with Q=%0d, required none", if6.Q);
        end else begin
          chk("err6_q_kept", int'(if6.Q), int'(err6_q.pop_front()));
        end
      end
      e6_prev = if6.sel_err;
    end
  end

  // driver helpers
  task automatic wait_idle8(input string tag);
    int n;
    n = 0;
    while (if8.dbg_state != IDLE && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle8"}, int'(if8.dbg_state == IDLE), 1);
  endtask

  task automatic wait_idle6(input string tag);
    int n;
    n = 0;
    while (if6.dbg_state != IDLE && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle6"}, int'(if6.dbg_state == IDLE), 1);
  endtask

  // stimulus
  initial begin
    int n;
    int busy_cycles;
    rst_n = 1'b1;
    hold8 = 1'b0;
    if8.sel_sw = 3'd0;
    if6.sel_sw = 3'd0;
    // slices 7..0: 00 01 11 10 00 11 10 01
    if8.pattern_bus = 16'b00_01_11_10_00_11_10_01;
    // slices 5..0: 01 11 00 01 11 10
    if6.pattern_bus = 12'b01_11_00_01_11_10;
`ifdef PATTERN_SEL_AUTO_EN
    if8.auto_en = 1'b0;
    if6.auto_en = 1'b0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_out_pattern", int'(if8.out_pattern), 0);
    chk("rst_q", int'(if8.Q), 0);
    chk("rst_load_req", int'(if8.load_req), 0);
    chk("rst_busy", int'(if8.busy), 0);
    chk("rst_sel_err", int'(if8.sel_err), 0);
    chk("rst_state", int'(if8.dbg_state), int'(BOOT));

    // power-on load of pattern 0 on both instances
    exp8_q.push_back('{q: 4'd0, pat: 2'b01, len: 8'd4});
    exp6_q.push_back('{q: 4'd0, pat: 2'b10, len: 8'd4});
    rst_n = 1'b1;
    wait_idle8("boot");
    wait_idle6("boot");
    chk("boot_q", int'(if8.Q), 0);
    chk("boot_pat", int'(if8.out_pattern), 1);
    chk("boot_busy", int'(if8.busy), 0);

    // 0 -> 5: debounced commit and one handshake
    exp8_q.push_back('{q: 4'd5, pat: 2'b11, len: 8'd4});
    if8.sel_sw = 3'd5;
    n = 0;
    while (!if8.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("commit_latency_window", int'(n >= 18 && n <= 21), 1);
    repeat (5) @(negedge clk);
    wait_idle8("sel5");
    chk("sel5_q", int'(if8.Q), 5);
    chk("sel5_pat", int'(if8.out_pattern), 3);

    // settle on 3, then a 5-cycle glitch to 4 must not commit
    exp8_q.push_back('{q: 4'd3, pat: 2'b00, len: 8'd4});
    if8.sel_sw = 3'd3;
    repeat (25) @(negedge clk);
    wait_idle8("sel3");
    chk("sel3_q", int'(if8.Q), 3);
    busy_cycles = 0;
    if8.sel_sw = 3'd4;
    repeat (5) begin
      @(negedge clk);
      if (if8.busy) busy_cycles++;
    end
    if8.sel_sw = 3'd3;
    repeat (40) begin
      @(negedge clk);
      if (if8.busy) busy_cycles++;
    end
    chk("glitch_no_busy", busy_cycles, 0);
    chk("glitch_q", int'(if8.Q), 3);

    // live pattern_bus change on the active slice shows after one cycle
    if8.pattern_bus = 16'b00_01_11_10_11_11_10_01;
    @(negedge clk);
    chk("live_bus_track", int'(if8.out_pattern), 3);
    if8.pattern_bus = 16'b00_01_11_10_00_11_10_01;
    @(negedge clk);
    chk("live_bus_restore", int'(if8.out_pattern), 0);

    // NUM_PAT=6: 7 and 6 are rejected, 5 is loaded
    err6_q.push_back(4'd0);
    if6.sel_sw = 3'd7;
    repeat (40) @(negedge clk);
    chk("err7_q", int'(if6.Q), 0);
    chk("err7_busy", int'(if6.busy), 0);
    err6_q.push_back(4'd0);
    if6.sel_sw = 3'd6;
    repeat (40) @(negedge clk);
    chk("err6_q", int'(if6.Q), 0);
    exp6_q.push_back('{q: 4'd5, pat: 2'b01, len: 8'd4});
    if6.sel_sw = 3'd5;
    repeat (40) @(negedge clk);
    wait_idle6("sel6_5");
    chk("n6_sel5_q", int'(if6.Q), 5);
    chk("n6_sel5_pat", int'(if6.out_pattern), 1);

    // ack held high: load of 4 takes one cycle, then 2 and 6 queue up while in HOLD
    hold8 = 1'b1;
    exp8_q.push_back('{q: 4'd4, pat: 2'b10, len: 8'd1});
    if8.sel_sw = 3'd4;
    repeat (30) @(negedge clk);
    chk("hold_state", int'(if8.dbg_state), int'(HOLD));
    if8.sel_sw = 3'd2;
    repeat (30) @(negedge clk);
    chk("pend2_q_kept", int'(if8.Q), 4);
    if8.sel_sw = 3'd6;
    repeat (30) @(negedge clk);
    chk("pend6_q_kept", int'(if8.Q), 4);
    exp8_q.push_back('{q: 4'd6, pat: 2'b01, len: 8'd4});
    hold8 = 1'b0;
    repeat (5) @(negedge clk);
    wait_idle8("lastwins");
    chk("lastwins_q", int'(if8.Q), 6);
    chk("lastwins_pat", int'(if8.out_pattern), 1);

    // reset in the middle of a handshake
    exp8_q.push_back('{q: 4'd5, pat: 2'b11, len: 8'd0});
    if8.sel_sw = 3'd5;
    n = 0;
    while (!if8.load_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("midreq_load_req_seen", int'(if8.load_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_load_req_drop", int'(if8.load_req), 0);
    chk("async_state_boot", int'(if8.dbg_state), int'(BOOT));
    chk("async_q_zero", int'(if8.Q), 0);
    if8.sel_sw = 3'd0;
    if6.sel_sw = 3'd0;
    repeat (3) @(negedge clk);
    exp8_q.push_back('{q: 4'd0, pat: 2'b01, len: 8'd4});
    exp6_q.push_back('{q: 4'd0, pat: 2'b10, len: 8'd4});
    rst_n = 1'b1;
    wait_idle8("reboot");
    wait_idle6("reboot");
    chk("reboot_q", int'(if8.Q), 0);
    chk("reboot_pat", int'(if8.out_pattern), 1);

    repeat (10) @(negedge clk);
    chk("exp8_drained", exp8_q.size(), 0);
    chk("exp6_drained", exp6_q.size(), 0);
    chk("err6_drained", err6_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_sel_ctrl.md
Name: pattern_sel_ctrl

Overview:
- Parametrised successor to the 4-way pattern selector for the Game of Life core.
- Synchronises and debounces the user selection switches, then registers one of NUM_PAT seed patterns onto out_pattern.
- Issues a req/ack load handshake to the life algorithm on power-up and on every committed selection change.
- Drives a zero-extended selection code for the 7-seg/LED status display.

Parameters:
- NUM_PAT, 8, number of selectable patterns (2..16).
- SEL_W, $clog2(NUM_PAT), selection switch width.
- PAT_W, 2, width of each pattern code.
- DEB_CYCLES, 16, consecutive stable cycles needed to commit a switch value (>=2).
- STAT_W, 4, width of the status output Q (>= SEL_W).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sel_sw  in  SEL_W  raw user switches, asynchronous to clk; MSB is the leftmost switch.
- pattern_bus  in  NUM_PAT*PAT_W  pattern k occupies bits [k*PAT_W +: PAT_W].
- load_ack  in  1  algorithm acknowledge (level).
- out_pattern  out  PAT_W  registered selected pattern.
- Q  out  STAT_W  active selection, zero-extended.
- load_req  out  1  load request to the algorithm.
- busy  out  1  high whenever state is not IDLE.
- sel_err  out  1  one-cycle pulse when a committed switch value is >= NUM_PAT.

Behaviour:
- Clocking/reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: all outputs 0; sync flops 0; debounce counter 0; committed value 0; active_sel 0; pending flag 0; state BOOT.
- Synchroniser: 2-flop on sel_sw gives sync_sel. Latency from a switch edge to sync_sel is 2 cycles.
- Debounce:
  - If sync_sel != candidate, load candidate and clear the counter.
  - Otherwise the counter increments, saturating at DEB_CYCLES-1.
  - When the counter reaches DEB_CYCLES-1 and candidate != committed, commit candidate for one cycle.
  - A glitch shorter than DEB_CYCLES cycles never commits.
- Range check: a commit with value >= NUM_PAT asserts sel_err for 1 cycle and is discarded; active_sel is unchanged.
- Valid commit:
  - In IDLE: active_sel <= value. The FSM goes to REQ on the next cycle.
  - In REQ or HOLD: value is stored in the pending register with pending=1. A newer commit overwrites pending (last-wins).
- out_pattern is pattern_bus slice[active_sel], registered. It updates 1 cycle after active_sel changes and also tracks live pattern_bus changes with 1-cycle latency.
- Q = active_sel zero-extended to STAT_W, combinational from the active_sel register.
- FSM:
  - BOOT -> REQ unconditionally after the first clock following reset release. This is the power-on load of pattern 0.
  - IDLE -> REQ on a valid commit.
  - REQ: load_req=1. If load_ack=1 go to HOLD; otherwise stay.
  - HOLD: load_req=0. Wait for load_ack=0, then go to IDLE. If pending=1 at that point, apply pending (active_sel <= pending, pending <= 0) and go to REQ instead of IDLE.
- Handshake timing:
  - load_req rises the cycle after entering REQ and drops the cycle after load_ack is sampled high.
  - out_pattern is stable from the first cycle load_req is high until HOLD exits.
  - A load_ack already high on entry to REQ is accepted immediately; minimum load_req pulse is 1 cycle.
- Simultaneous events: a commit in the same cycle HOLD exits with pending=1 overwrites pending first; the newest value is loaded.
- Reset mid-handshake: asynchronous return to BOOT. load_req drops immediately, and a new load of pattern 0 is requested.

Optional Feature:
- Macro: PATTERN_SEL_AUTO_EN.
- With the macro:
  - Adds input auto_en (1 bit) and parameter AUTO_PERIOD (default 50_000_000).
  - While auto_en=1 and state is IDLE, a period counter advances active_sel by 1 every AUTO_PERIOD cycles, wrapping NUM_PAT-1 -> 0. Each advance issues a normal load handshake.
  - Switch commits are still accepted and reset the period counter.
  - The period counter holds while busy.
- Without the macro: no auto_en port and no counter logic; behaviour is exactly as above.

Decomposition:
- Package gol_pkg:
  - FSM state enum {BOOT, IDLE, REQ, HOLD}, 2 bits.
  - Default NUM_PAT/PAT_W constants.
  - Pattern index localparams GLIDER=0, BLINKER=1, BEACON=2, ACORN=3.
- Sub-module sel_debounce (parameters W, DEB_CYCLES; ports clk, rst_n, din, dout, commit) contains the synchroniser plus debounce counter.

Test Plan:
- Reset release, NUM_PAT=8, pattern_bus slice0=2'b01, load_ack tied to load_req delayed by 3 cycles -> out_pattern=01, Q=0000, one load_req pulse of 4 cycles, busy returns 0.
- sel_sw 000->101 held 40 cycles -> commit after 2+16 cycles, Q=0101, out_pattern=slice5, exactly one handshake.
- sel_sw toggled 3->4->3 with 5-cycle glitch (DEB_CYCLES=16) -> no commit, no load_req, Q unchanged.
- NUM_PAT=6, sel_sw=111 held 40 cycles -> sel_err single pulse, Q unchanged, no load_req.
- Commits of 2 then 6 while in HOLD with load_ack held high -> after ack drops, Q=0110, second handshake only for 6 (last-wins).
- rst_n pulled low while load_req=1 -> load_req=0 asynchronously; after release Q=0 and a new request.
